// File: rtl/kernel_loader_if.sv
// kernel_loader_if
// Valid/ready word stream that carries kernel sets into kernel_loader.
// The master drives the words. The slave (the loader) drives s_ready.
//   s_data  : one kernel word, in the order K1..K9 then bias
//   s_valid : s_data holds a word
//   s_last  : marks the 10th (bias) word of a set
//   s_ready : the loader can take a word this cycle
interface kernel_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/kernel_loader.sv
// kernel_loader
// Producer side of kernel_switch. A stream delivers 10-word kernel sets
// (K1..K9, bias) into a shadow buffer. A full shadow buffer is swapped into
// the active registers, which drive kernel_switch directly. sel then steps
// 0..3 on each core step request. Each set repeats for reuse_count passes.
// The next set can load while the current set runs.
//
// Ports:
//   clk, rstn     : clock (rising edge), asynchronous active-low reset
//   s (slave)     : kernel word stream (s_data/s_valid/s_last in, s_ready out)
//   reuse_count   : passes per set, sampled with the first word (0 acts as 1)
//   step          : core consumed the current sel and wants the next one
//   K1..K9, bias  : active kernel words
//   sel           : kernel_switch select
//   kernel_valid  : the active registers hold a live set
//   pass_done     : one-cycle pulse when a step is accepted at sel=3
//   err_last      : one-cycle pulse on an s_last/word-count mismatch
//
// Optional build macro KERNEL_LOADER_ZERO_ON_IDLE_EN:
//   when defined, the active words are cleared on the RUN->IDLE transition.
//   When undefined, they keep the last set while IDLE.
module kernel_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int REUSE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    kernel_loader_if.slave         s,
    input  logic [REUSE_WIDTH-1:0] reuse_count,
    input  logic                   step,
    output logic [DATA_WIDTH-1:0]  K1,
    output logic [DATA_WIDTH-1:0]  K2,
    output logic [DATA_WIDTH-1:0]  K3,
    output logic [DATA_WIDTH-1:0]  K4,
    output logic [DATA_WIDTH-1:0]  K5,
    output logic [DATA_WIDTH-1:0]  K6,
    output logic [DATA_WIDTH-1:0]  K7,
    output logic [DATA_WIDTH-1:0]  K8,
    output logic [DATA_WIDTH-1:0]  K9,
    output logic [DATA_WIDTH-1:0]  bias,
    output logic [1:0]             sel,
    output logic                   kernel_valid,
    output logic                   pass_done,
    output logic                   err_last
);
    localparam logic [REUSE_WIDTH-1:0] ONE = REUSE_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  shadow [10];
    logic [DATA_WIDTH-1:0]  active [10];
    logic [3:0]             wc;
    logic                   shadow_full;
    logic [REUSE_WIDTH-1:0] reuse_sh, reuse_act, pass_cnt, pass_next;
    logic [1:0]             sel_next;
    logic                   kv_next, pd_next, load_active;
    logic                   accept, last_step, swap;
`ifdef KERNEL_LOADER_ZERO_ON_IDLE_EN
    logic                   clear_active;
`endif

    assign s.s_ready = ~shadow_full;
    assign accept    = s.s_valid & ~shadow_full;
    assign last_step = (state == RUN) & step & (sel == 2'd3) & (pass_cnt == reuse_act - ONE);
    // A full shadow is swapped in as soon as nothing is running. It is also
    // swapped in on the edge that ends the final pass, so no bubble appears.
    assign swap      = shadow_full & ((state == IDLE) | last_step);

    assign K1   = active[0];
    assign K2   = active[1];
    assign K3   = active[2];
    assign K4   = active[3];
    assign K5   = active[4];
    assign K6   = active[5];
    assign K7   = active[6];
    assign K8   = active[7];
    assign K9   = active[8];
    assign bias = active[9];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and next values of the registered outputs. A swap overrides
    // the normal end-of-pass handling.
    always_comb begin
        state_next  = state;
        sel_next    = sel;
        kv_next     = kernel_valid;
        pd_next     = 1'b0;
        pass_next   = pass_cnt;
        load_active = 1'b0;
`ifdef KERNEL_LOADER_ZERO_ON_IDLE_EN
        clear_active = 1'b0;
`endif
        if (state == RUN && step) begin
            if (sel != 2'd3) begin
                sel_next = sel + 2'd1;
            end else begin
                sel_next  = 2'd0;
                pd_next   = 1'b1;
                pass_next = pass_cnt + ONE;
                if (last_step) begin
                    state_next = IDLE;
                    kv_next    = 1'b0;
`ifdef KERNEL_LOADER_ZERO_ON_IDLE_EN
                    clear_active = 1'b1;
`endif
                end
            end
        end
        if (swap) begin
            load_active = 1'b1;
            sel_next    = 2'd0;
            pass_next   = '0;
            state_next  = RUN;
            kv_next     = 1'b1;
`ifdef KERNEL_LOADER_ZERO_ON_IDLE_EN
            clear_active = 1'b0;
`endif
        end
    end

    // Sequencer outputs and the active register bank
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel          <= 2'd0;
            kernel_valid <= 1'b0;
            pass_done    <= 1'b0;
            pass_cnt     <= '0;
            reuse_act    <= '0;
            for (int i = 0; i < 10; i++) active[i] <= '0;
        end else begin
            sel          <= sel_next;
            kernel_valid <= kv_next;
            pass_done    <= pd_next;
            pass_cnt     <= pass_next;
            if (load_active) begin
                reuse_act <= reuse_sh;
                for (int i = 0; i < 10; i++) active[i] <= shadow[i];
            end
`ifdef KERNEL_LOADER_ZERO_ON_IDLE_EN
            else if (clear_active) begin
                for (int i = 0; i < 10; i++) active[i] <= '0;
            end
`endif
        end
    end

    // Stream side. wc counts words into the shadow buffer. An early s_last
    // throws away the partial set. A missing s_last on the 10th word only
    // raises err_last, and the set is still kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wc          <= 4'd0;
            shadow_full <= 1'b0;
            reuse_sh    <= '0;
            err_last    <= 1'b0;
            for (int i = 0; i < 10; i++) shadow[i] <= '0;
        end else begin
            err_last <= 1'b0;
            if (swap) shadow_full <= 1'b0;
            if (accept) begin
                shadow[wc] <= s.s_data;
                if (wc == 4'd0) reuse_sh <= (reuse_count == '0) ? ONE : reuse_count;
                if (wc == 4'd9) begin
                    shadow_full <= 1'b1;
                    wc          <= 4'd0;
                    if (!s.s_last) err_last <= 1'b1;
                end else if (s.s_last) begin
                    wc       <= 4'd0;
                    err_last <= 1'b1;
                end else begin
                    wc <= wc + 4'd1;
                end
            end
        end
    end
endmodule
